// File: rtl/mant_div_iter.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Delivers quotient, remainder, sticky (inexact) and divide-by-zero to the normalize/round stage.
module mant_div_iter #(
    parameter int DWIDTH = 24,
    parameter int CWIDTH = $clog2(DWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder,
    output logic              sticky,
    output logic              div_zero
);
    // state  | meaning
    // S_IDLE | waiting for an operand pair, in_ready high
    // S_CALC | shifting out one quotient bit per edge, counter counts down to 0
    // S_DONE | result held on outputs until out_ready, out_valid high
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CWIDTH-1:0] r_cnt;
    logic [DWIDTH-1:0] r_d;
    logic [DWIDTH-1:0] r_q;
    logic [DWIDTH-1:0] r_rem;
    logic              r_sticky;
    logic              r_div_zero;

    logic [DWIDTH:0]   w_shift;
    logic [DWIDTH:0]   w_trial;
    logic [DWIDTH:0]   w_rem_nxt;
    logic              w_qbit;

    // rem < d always holds, so the partial remainder never needs its top bit stored
    always_comb begin
        w_shift   = {r_rem, r_q[DWIDTH-1]};
        w_trial   = w_shift - {1'b0, r_d};
        w_qbit    = ~w_trial[DWIDTH];
        w_rem_nxt = w_qbit ? w_trial : w_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_d        <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_sticky   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_d <= divisor;
                        if (divisor == '0) begin
                            r_q        <= '1;
                            r_rem      <= dividend;
                            r_sticky   <= |dividend;
                            r_div_zero <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_q        <= dividend;
                            r_rem      <= '0;
                            r_cnt      <= CWIDTH'(DWIDTH - 1);
                            r_sticky   <= 1'b0;
                            r_div_zero <= 1'b0;
                            r_state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt[DWIDTH-1:0];
                    r_q   <= {r_q[DWIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CWIDTH'(1);
                    if (r_cnt == '0) begin
                        r_sticky <= |w_rem_nxt;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_q;
    assign remainder = r_rem;
    assign sticky    = r_sticky;
    assign div_zero  = r_div_zero;

endmodule
